// File: rtl/mux_rr_sched_pkg.sv
// Shared types and default sizing for the round-robin mux scheduler.
// Optional feature macro used by the top: MUX_RR_SCHED_LOCK_EN.
package mux_rr_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int NREQ_DEF = 16;
    localparam int W_DEF    = 1;

endpackage

// File: rtl/mux_rr_sched_rr_pick.sv
// Combinational rotating priority encoder: first set req bit at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter  int NREQ = 16,
    localparam int SELW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            any
);

    logic [SELW-1:0] cand;

    // Scan from the far end so the lowest offset from ptr is written last and wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + SELW'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler owning the select of a shared NREQ:1 data mux.
// Define MUX_RR_SCHED_LOCK_EN to add the lock port for back-to-back beats.
module mux_rr_sched
    import mux_rr_sched_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int W    = W_DEF,
    localparam int SELW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] data_in,
`ifdef MUX_RR_SCHED_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    output logic [NREQ-1:0]   grant,
    output logic [SELW-1:0]   sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data
);

    state_e            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              valid_q, valid_d;

    logic [SELW-1:0]   pick_idx;
    logic              pick_any;
    logic              keep_grant;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef MUX_RR_SCHED_LOCK_EN
    assign keep_grant = lock[sel_q];
`else
    assign keep_grant = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (pick_any) begin
                    sel_d           = pick_idx;
                    grant_d[pick_idx] = 1'b1;
                    valid_d         = 1'b1;
                    state_d         = BUSY;
                end
            end
            BUSY: begin
                // A locked transfer keeps the same grant with no idle cycle.
                if (valid_q && out_ready && !keep_grant) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q + SELW'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_data  = data_in[sel_q*W +: W];

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_mux_rr_sched;

    localparam int NREQ = 16;
    localparam int W    = 1;
    localparam int SELW = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] data_in = '0;
    logic [NREQ-1:0]   grant;
    logic [SELW-1:0]   sel;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [W-1:0]      out_data;
`ifdef MUX_RR_SCHED_LOCK_EN
    logic [NREQ-1:0]   lock = '0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: busy flag, granted index, and next-priority index.
    bit m_busy = 1'b0;
    int m_sel  = 0;
    int m_ptr  = 0;

    mux_rr_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
`ifdef MUX_RR_SCHED_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit locked;
        locked = 1'b0;
`ifdef MUX_RR_SCHED_LOCK_EN
        locked = lock[m_sel];
`endif
        if (rst) begin
            m_busy = 1'b0;
            m_sel  = 0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                if (req[(m_ptr + k) % NREQ]) begin
                    m_sel  = (m_ptr + k) % NREQ;
                    m_busy = 1'b1;
                    break;
                end
            end
        end else if (out_ready && !locked) begin
            m_busy = 1'b0;
            m_ptr  = (m_sel + 1) % NREQ;
        end
    endtask

    task automatic check_model();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_busy) g[m_sel] = 1'b1;
        chk("model_valid", out_valid, m_busy);
        chk("model_sel",   sel,       m_sel);
        chk("model_grant", grant,     g);
        chk("model_data",  out_data,  data_in[m_sel*W +: W]);
    endtask

    // One clock: inputs already driven, model advances on the same edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        out_ready = 1'b1;
`ifdef MUX_RR_SCHED_LOCK_EN
        lock = '0;
`endif
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] req;
        logic            rdy;
        logic            exp_valid;
        int              exp_sel;
        logic [NREQ-1:0] exp_grant;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // Single request, ptr advance, then the wrap from ptr=15.
        vecs[0]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 0,  16'h0000};
        vecs[1]  = '{1'b0, 16'h0001, 1'b1, 1'b1, 0,  16'h0001};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 0,  16'h0000};
        vecs[3]  = '{1'b0, 16'h0003, 1'b1, 1'b1, 1,  16'h0002};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1,  16'h0000};
        vecs[5]  = '{1'b0, 16'h4000, 1'b1, 1'b1, 14, 16'h4000};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 14, 16'h0000};
        vecs[7]  = '{1'b0, 16'h4001, 1'b1, 1'b1, 0,  16'h0001};
        vecs[8]  = '{1'b0, 16'h4001, 1'b1, 1'b0, 0,  16'h0000};
        vecs[9]  = '{1'b0, 16'h4001, 1'b1, 1'b1, 14, 16'h4000};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 14, 16'h0000};

        #2;
        for (int i = 0; i < 11; i++) begin
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            cyc();
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_sel", i),   sel,       vecs[i].exp_sel);
            chk($sformatf("vec%0d_grant", i), grant,     vecs[i].exp_grant);
        end

        // All requesting with ready held: sel walks 0..15,0 with one idle cycle each.
        do_reset();
        req = 16'hFFFF;
        for (int k = 0; k <= NREQ; k++) begin
            cyc();
            chk("sweep_valid_hi", out_valid, 1'b1);
            chk("sweep_sel", sel, k % NREQ);
            cyc();
            chk("sweep_valid_lo", out_valid, 1'b0);
        end

        // Backpressure: everything frozen while out_ready is low.
        do_reset();
        data_in   = 16'hAAAA;
        req       = 16'h0002;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_sel",   sel,       1);
            chk("bp_grant", grant,     16'h0002);
            chk("bp_data",  out_data,  1'b1);
        end
        out_ready = 1'b1;
        req       = '0;
        cyc();
        chk("bp_release_valid", out_valid, 1'b0);

        // Reset during BUSY drops the transfer and restarts priority at 0.
        do_reset();
        req = 16'h0004;
        cyc();
        req = '0;
        cyc();
        req       = 16'h0008;
        out_ready = 1'b0;
        cyc();
        chk("rst_mid_sel", sel, 3);
        cyc();
        rst = 1'b1;
        cyc();
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_grant", grant, 16'h0000);
        chk("rst_mid_sel0",  sel, 0);
        rst = 1'b0;
        req = 16'h0009;
        cyc();
        chk("rst_restart_sel", sel, 0);

`ifdef MUX_RR_SCHED_LOCK_EN
        // Locked requester gets four consecutive beats, then releases.
        do_reset();
        req  = 16'h0010;
        lock = 16'h0010;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("lock_valid", out_valid, 1'b1);
            chk("lock_sel",   sel,       4);
        end
        lock = '0;
        req  = '0;
        cyc();
        chk("lock_release", out_valid, 1'b0);
`endif

        // Randomized traffic checked every cycle against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req       = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) & NREQ'($urandom)
                                                    : NREQ'($urandom);
            data_in   = (NREQ*W)'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef MUX_RR_SCHED_LOCK_EN
            lock      = NREQ'($urandom) & NREQ'($urandom);
`endif
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
